// File: rtl/cpu_control_seq.sv
// Sequential Thumb-subset control unit: registered decode bundle, multi-cycle FPU issue
// with a latency counter, a wrong-path flush window and a one-cycle flag-hazard bubble.
module cpu_control_seq #(
    parameter int LAT_ADD     = 2,
    parameter int LAT_MUL     = 3,
    parameter int LAT_DIV     = 8,
    parameter int FLUSH_DEPTH = 2,
    parameter int FLAG_BUBBLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    input  logic [3:0]  FlagsReg,
    output logic        stall,
    output logic        fpu_start,
    output logic        ctrl_valid,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemRead,
    output logic        ALUorFPU,
    output logic        selOpA,
    output logic        brEx,
    output logic        Branch,
    output logic [1:0]  ShiftDir,
    output logic [3:0]  keepFlags,
    output logic [1:0]  Reg1Loc,
    output logic [1:0]  Reg2Loc,
    output logic [1:0]  Reg3Loc,
    output logic [2:0]  selOpB,
    output logic [2:0]  ALUOp,
    output logic [1:0]  FPUOp,
    output logic [1:0]  brSel,
    output logic [1:0]  selWrData
);
    localparam int CW = $clog2(LAT_DIV + 1);
    localparam int FW = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic [1:0] {RUN, FPU_BUSY, FLUSH} state_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       alu_or_fpu;
        logic       sel_op_a;
        logic       br_ex;
        logic       branch;
        logic [1:0] shift_dir;
        logic [3:0] keep_flags;
        logic [1:0] reg1_loc;
        logic [1:0] reg2_loc;
        logic [1:0] reg3_loc;
        logic [2:0] sel_op_b;
        logic [2:0] alu_op;
        logic [1:0] fpu_op;
        logic [1:0] br_sel;
        logic [1:0] sel_wr_data;
    } bundle_t;

    // Every field defaults to 0 except brSel, whose idle value means "no branch".
    function automatic bundle_t idle_bundle();
        bundle_t b;
        b = '0;
        b.br_sel = 2'b11;
        return b;
    endfunction

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [FW-1:0]  fcnt;
    logic           flag_pend;
    logic [1:0]     fpu_op_held;
    bundle_t        out_q;

    bundle_t        dec;
    logic           is_fp, is_bcc, taken, cond_true, hazard;
    logic [CW-1:0]  fp_lat;
    logic [9:0]     op;
    logic           n_f, z_f, c_f, v_f;
    logic           unused_bits;

    assign op = instr[15:6];
    assign {n_f, z_f, c_f, v_f} = FlagsReg;
    assign unused_bits = ^instr[5:0];

    always_comb begin
        case (instr[11:8])
            4'h0:    cond_true = z_f;
            4'h1:    cond_true = !z_f;
            4'h2:    cond_true = c_f;
            4'h3:    cond_true = !c_f;
            4'h4:    cond_true = n_f;
            4'h5:    cond_true = !n_f;
            4'h6:    cond_true = v_f;
            4'h7:    cond_true = !v_f;
            4'h8:    cond_true = c_f && !z_f;
            4'h9:    cond_true = !c_f || z_f;
            4'hA:    cond_true = (n_f == v_f);
            4'hB:    cond_true = (n_f != v_f);
            4'hC:    cond_true = !z_f && (n_f == v_f);
            4'hD:    cond_true = z_f || (n_f != v_f);
            default: cond_true = 1'b1;
        endcase
    end

    always_comb begin
        case (instr[10:9])
            2'b10:   fp_lat = CW'(LAT_MUL - 1);
            2'b11:   fp_lat = CW'(LAT_DIV - 1);
            default: fp_lat = CW'(LAT_ADD - 1);
        endcase
    end

    // Each class overrides only its own fields on top of the idle bundle.
    always_comb begin
        dec    = idle_bundle();
        is_fp  = 1'b0;
        is_bcc = 1'b0;
        taken  = 1'b0;
        casez (op)
            10'b00011?????: begin
                dec.reg_write   = 1'b1;
                dec.keep_flags  = 4'b1111;
                dec.reg1_loc    = 2'b01;
                dec.sel_wr_data = 2'b01;
                dec.sel_op_b    = {2'b00, op[4]};
                dec.alu_op      = {2'b00, op[3]};
            end
            10'b10110000??: begin
                dec.reg_write   = 1'b1;
                dec.reg3_loc    = 2'b01;
                dec.sel_op_b    = 3'd2;
                dec.alu_op      = {2'b00, op[1]};
                dec.sel_wr_data = 2'b01;
            end
            10'b0010??????: begin
                dec.reg_write   = 1'b1;
                dec.keep_flags  = 4'b1100;
                dec.reg3_loc    = 2'b10;
                dec.sel_wr_data = 2'b10;
            end
            10'b010001100?: begin
                dec.reg_write   = 1'b1;
                dec.reg2_loc    = 2'b11;
                dec.alu_op      = 3'd6;
                dec.sel_wr_data = 2'b01;
            end
            10'b0100001010: begin
                dec.keep_flags = 4'b1111;
                dec.reg1_loc   = 2'b10;
                dec.reg2_loc   = 2'b01;
                dec.alu_op     = 3'd1;
            end
            10'b0100000000, 10'b0100001100, 10'b0100000001, 10'b0100001111,
            10'b0100000010, 10'b0100000011, 10'b0100000100, 10'b0100000111: begin
                dec.reg_write   = 1'b1;
                dec.keep_flags  = 4'b1100;
                dec.reg1_loc    = 2'b01;
                dec.reg2_loc    = 2'b10;
                dec.sel_wr_data = 2'b01;
                case (op[3:0])
                    4'b0000: dec.alu_op = 3'd2;
                    4'b1100: dec.alu_op = 3'd3;
                    4'b0001: dec.alu_op = 3'd4;
                    4'b1111: dec.alu_op = 3'd5;
                    4'b0010: begin dec.shift_dir = 2'd0; dec.sel_wr_data = 2'b00; end
                    4'b0011: begin dec.shift_dir = 2'd1; dec.sel_wr_data = 2'b00; end
                    4'b0100: begin dec.shift_dir = 2'd2; dec.sel_wr_data = 2'b00; end
                    default: begin dec.shift_dir = 2'd3; dec.sel_wr_data = 2'b00; end
                endcase
            end
            10'b01100?????: begin
                dec.mem_write = 1'b1;
                dec.reg1_loc  = 2'b01;
                dec.reg2_loc  = 2'b10;
                dec.sel_op_b  = 3'd3;
            end
            10'b01101?????: begin
                dec.reg_write   = 1'b1;
                dec.mem_read    = 1'b1;
                dec.reg1_loc    = 2'b01;
                dec.sel_op_b    = 3'd3;
                dec.sel_wr_data = 2'b11;
            end
            10'b1101??????: begin
                if (instr[11:8] != 4'hF) begin
                    is_bcc     = 1'b1;
                    dec.branch = 1'b1;
                    taken      = cond_true;
                    dec.br_sel = cond_true ? 2'b01 : 2'b11;
                end
            end
            10'b11100?????: begin
                dec.branch = 1'b1;
                dec.br_sel = 2'b10;
                taken      = 1'b1;
            end
            10'b0100010100: begin
                dec.branch      = 1'b1;
                dec.reg_write   = 1'b1;
                dec.reg3_loc    = 2'b11;
                dec.br_sel      = 2'b00;
                dec.sel_wr_data = 2'b10;
                taken           = 1'b1;
            end
            10'b010001110?: begin
                dec.branch   = 1'b1;
                dec.br_ex    = 1'b1;
                dec.reg2_loc = 2'b11;
                taken        = 1'b1;
            end
            10'b01110?????: begin
                is_fp          = 1'b1;
                dec.alu_or_fpu = 1'b1;
                dec.reg1_loc   = 2'b01;
                dec.sel_op_b   = 3'd2;
                dec.fpu_op     = op[4:3];
            end
            10'b0111100000: begin
                dec.alu_or_fpu = 1'b1;
                dec.keep_flags = 4'b1111;
                dec.reg1_loc   = 2'b10;
                dec.reg2_loc   = 2'b01;
                dec.fpu_op     = 2'b01;
            end
            default: ;
        endcase
    end

    assign hazard = (FLAG_BUBBLE != 0) && (state == RUN) && flag_pend && instr_valid && is_bcc;
    assign stall  = (state == FPU_BUSY) || hazard;

    // Squashed wrong-path instructions never update flag_pend: they are not executed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            fcnt        <= '0;
            flag_pend   <= 1'b0;
            fpu_op_held <= 2'b00;
            out_q       <= idle_bundle();
            fpu_start   <= 1'b0;
            ctrl_valid  <= 1'b0;
        end else begin
            out_q      <= idle_bundle();
            fpu_start  <= 1'b0;
            ctrl_valid <= 1'b0;
            case (state)
                RUN: begin
                    if (hazard) begin
                        flag_pend <= 1'b0;
                    end else if (instr_valid) begin
                        out_q      <= dec;
                        ctrl_valid <= 1'b1;
                        flag_pend  <= (dec.keep_flags != 4'b0000);
                        if (is_fp) begin
                            fpu_start   <= 1'b1;
                            cnt         <= fp_lat;
                            fpu_op_held <= dec.fpu_op;
                            state       <= FPU_BUSY;
                        end else if (taken) begin
                            fcnt  <= FW'(FLUSH_DEPTH);
                            state <= FLUSH;
                        end
                    end
                end
                FPU_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        ctrl_valid        <= 1'b1;
                        out_q.alu_or_fpu  <= 1'b1;
                        out_q.reg_write   <= 1'b1;
                        out_q.sel_wr_data <= 2'b01;
                        out_q.fpu_op      <= fpu_op_held;
                        state             <= RUN;
                    end
                end
                FLUSH: begin
                    if (instr_valid) begin
                        fcnt <= fcnt - FW'(1);
                        if (fcnt == FW'(1)) state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign RegWrite  = out_q.reg_write;
    assign MemWrite  = out_q.mem_write;
    assign MemRead   = out_q.mem_read;
    assign ALUorFPU  = out_q.alu_or_fpu;
    assign selOpA    = out_q.sel_op_a;
    assign brEx      = out_q.br_ex;
    assign Branch    = out_q.branch;
    assign ShiftDir  = out_q.shift_dir;
    assign keepFlags = out_q.keep_flags;
    assign Reg1Loc   = out_q.reg1_loc;
    assign Reg2Loc   = out_q.reg2_loc;
    assign Reg3Loc   = out_q.reg3_loc;
    assign selOpB    = out_q.sel_op_b;
    assign ALUOp     = out_q.alu_op;
    assign FPUOp     = out_q.fpu_op;
    assign brSel     = out_q.br_sel;
    assign selWrData = out_q.sel_wr_data;
endmodule

// File: tb/tb_cpu_control_seq.sv
// Bench for cpu_control_seq: directed scenarios plus randomized instruction streams
// compared cycle by cycle against a transaction-level reference model.
module tb_cpu_control_seq;
    localparam int LAT_ADD = 2, LAT_MUL = 3, LAT_DIV = 8, FLUSH_DEPTH = 2;

    typedef struct packed {
        logic       cv, fs, rw, mw, mr, af, sa, bx, br;
        logic [1:0] sd;
        logic [3:0] kf;
        logic [1:0] r1, r2, r3;
        logic [2:0] ob, ao;
        logic [1:0] fo, bs, wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic [3:0]  FlagsReg;

    logic stall, fpu_start, ctrl_valid, RegWrite, MemWrite, MemRead, ALUorFPU, selOpA, brEx, Branch;
    logic [1:0] ShiftDir, Reg1Loc, Reg2Loc, Reg3Loc, FPUOp, brSel, selWrData;
    logic [3:0] keepFlags;
    logic [2:0] selOpB, ALUOp;

    logic stall_b, fpu_start_b, ctrl_valid_b, RegWrite_b, MemWrite_b, MemRead_b, ALUorFPU_b;
    logic selOpA_b, brEx_b, Branch_b;
    logic [1:0] ShiftDir_b, Reg1Loc_b, Reg2Loc_b, Reg3Loc_b, FPUOp_b, brSel_b, selWrData_b;
    logic [3:0] keepFlags_b;
    logic [2:0] selOpB_b, ALUOp_b;

    int total = 0;
    int bad = 0;

    int         busy_left = 0;
    int         squash_left = 0;
    bit         pend = 0;
    logic [1:0] wb_op = 2'b00;
    logic       seen_stall, seen_stall_b, last_stall;

    always #5 clk = ~clk;

    cpu_control_seq #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
                      .FLUSH_DEPTH(FLUSH_DEPTH), .FLAG_BUBBLE(1)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .FlagsReg(FlagsReg),
        .stall(stall), .fpu_start(fpu_start), .ctrl_valid(ctrl_valid), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .MemRead(MemRead), .ALUorFPU(ALUorFPU), .selOpA(selOpA), .brEx(brEx),
        .Branch(Branch), .ShiftDir(ShiftDir), .keepFlags(keepFlags), .Reg1Loc(Reg1Loc),
        .Reg2Loc(Reg2Loc), .Reg3Loc(Reg3Loc), .selOpB(selOpB), .ALUOp(ALUOp), .FPUOp(FPUOp),
        .brSel(brSel), .selWrData(selWrData));

    cpu_control_seq #(.LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV),
                      .FLUSH_DEPTH(FLUSH_DEPTH), .FLAG_BUBBLE(0)) dut_nobubble (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid), .FlagsReg(FlagsReg),
        .stall(stall_b), .fpu_start(fpu_start_b), .ctrl_valid(ctrl_valid_b), .RegWrite(RegWrite_b),
        .MemWrite(MemWrite_b), .MemRead(MemRead_b), .ALUorFPU(ALUorFPU_b), .selOpA(selOpA_b),
        .brEx(brEx_b), .Branch(Branch_b), .ShiftDir(ShiftDir_b), .keepFlags(keepFlags_b),
        .Reg1Loc(Reg1Loc_b), .Reg2Loc(Reg2Loc_b), .Reg3Loc(Reg3Loc_b), .selOpB(selOpB_b),
        .ALUOp(ALUOp_b), .FPUOp(FPUOp_b), .brSel(brSel_b), .selWrData(selWrData_b));

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic exp_t idleExp();
        exp_t e;
        e = '0;
        e.bs = 2'b11;
        return e;
    endfunction

    function automatic exp_t dutBundle();
        return {ctrl_valid, fpu_start, RegWrite, MemWrite, MemRead, ALUorFPU, selOpA, brEx, Branch,
                ShiftDir, keepFlags, Reg1Loc, Reg2Loc, Reg3Loc, selOpB, ALUOp, FPUOp, brSel, selWrData};
    endfunction

    function automatic bit condHolds(input logic [3:0] cc, input logic [3:0] f);
        bit n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0: return z;          4'd1: return !z;
            4'd2: return c;          4'd3: return !c;
            4'd4: return n;          4'd5: return !n;
            4'd6: return v;          4'd7: return !v;
            4'd8: return c && !z;    4'd9: return !c || z;
            4'd10: return n == v;    4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1;
        endcase
    endfunction

    // Reference decode written straight from the instruction-class table.
    task automatic decodeRef(input logic [15:0] i, input logic [3:0] f, output exp_t d,
                             output bit fp, output bit bcc, output bit tk, output int lat);
        d = idleExp(); fp = 0; bcc = 0; tk = 0; lat = 0;
        if (i[15:11] == 5'b00011) begin
            d.rw = 1; d.kf = 4'hF; d.r1 = 1; d.wd = 1; d.ob = i[10] ? 3'd1 : 3'd0; d.ao = i[9] ? 3'd1 : 3'd0;
        end else if (i[15:8] == 8'hB0) begin
            d.rw = 1; d.r3 = 1; d.ob = 2; d.ao = i[7] ? 3'd1 : 3'd0; d.wd = 1;
        end else if (i[15:12] == 4'b0010) begin
            d.rw = 1; d.kf = 4'hC; d.r3 = 2; d.wd = 2;
        end else if (i[15:7] == 9'b010001100) begin
            d.rw = 1; d.r2 = 3; d.ao = 6; d.wd = 1;
        end else if (i[15:6] == 10'b0100001010) begin
            d.kf = 4'hF; d.r1 = 2; d.r2 = 1; d.ao = 1;
        end else if (i[15:10] == 6'b010000) begin
            case (i[9:6])
                4'h0: d.ao = 2;  4'hC: d.ao = 3;  4'h1: d.ao = 4;  4'hF: d.ao = 5;
                4'h2: d.sd = 0;  4'h3: d.sd = 1;  4'h4: d.sd = 2;  4'h7: d.sd = 3;
                default: ;
            endcase
            if (i[9:6] inside {4'h0, 4'hC, 4'h1, 4'hF, 4'h2, 4'h3, 4'h4, 4'h7}) begin
                d.rw = 1; d.kf = 4'hC; d.r1 = 1; d.r2 = 2;
                d.wd = (i[9:6] inside {4'h2, 4'h3, 4'h4, 4'h7}) ? 2'd0 : 2'd1;
            end
        end else if (i[15:11] == 5'b01100) begin
            d.mw = 1; d.r1 = 1; d.r2 = 2; d.ob = 3;
        end else if (i[15:11] == 5'b01101) begin
            d.rw = 1; d.mr = 1; d.r1 = 1; d.ob = 3; d.wd = 3;
        end else if (i[15:12] == 4'b1101 && i[11:8] != 4'hF) begin
            bcc = 1; d.br = 1; tk = condHolds(i[11:8], f); d.bs = tk ? 2'b01 : 2'b11;
        end else if (i[15:11] == 5'b11100) begin
            d.br = 1; d.bs = 2; tk = 1;
        end else if (i[15:6] == 10'b0100010100) begin
            d.br = 1; d.rw = 1; d.r3 = 3; d.bs = 0; d.wd = 2; tk = 1;
        end else if (i[15:7] == 9'b010001110) begin
            d.br = 1; d.bx = 1; d.r2 = 3; tk = 1;
        end else if (i[15:11] == 5'b01110) begin
            fp = 1; d.af = 1; d.r1 = 1; d.ob = 2; d.fo = i[10:9];
            lat = (i[10:9] == 2'b11) ? LAT_DIV : (i[10:9] == 2'b10) ? LAT_MUL : LAT_ADD;
        end else if (i[15:6] == 10'b0111100000) begin
            d.af = 1; d.kf = 4'hF; d.r1 = 2; d.r2 = 1; d.fo = 1;
        end
    endtask

    // One cycle of the reference machine: stall for the current inputs, outputs after the edge.
    task automatic modelStep(input logic [15:0] i, input logic v, input logic [3:0] f, input logic r,
                             output logic exp_stall, output exp_t nxt);
        exp_t d;
        bit fp, bcc, tk;
        int lat;
        nxt = idleExp();
        decodeRef(i, f, d, fp, bcc, tk, lat);
        if (busy_left > 0) begin
            exp_stall = 1;
            if (busy_left == 1) begin
                nxt.cv = 1; nxt.af = 1; nxt.rw = 1; nxt.wd = 2'b01; nxt.fo = wb_op;
            end
            busy_left--;
        end else if (squash_left > 0) begin
            exp_stall = 0;
            if (v) squash_left--;
        end else if (pend && v && bcc) begin
            exp_stall = 1;
            pend = 0;
        end else begin
            exp_stall = 0;
            if (v) begin
                nxt = d;
                nxt.cv = 1;
                pend = (d.kf != 0);
                if (fp) begin
                    nxt.fs = 1; busy_left = lat; wb_op = d.fo;
                end else if (tk) begin
                    squash_left = FLUSH_DEPTH;
                end
            end
        end
        if (r) begin
            nxt = idleExp(); busy_left = 0; squash_left = 0; pend = 0;
        end
    endtask

    task automatic applyStimulus(input logic [15:0] i, input logic v, input logic [3:0] f, input logic r);
        logic es;
        exp_t nx;
        instr = i; instr_valid = v; FlagsReg = f; reset = r;
        modelStep(i, v, f, r, es, nx);
        @(negedge clk);
        seen_stall = stall;
        seen_stall_b = stall_b;
        checkOutput("stall", 64'(stall), 64'(es));
        @(posedge clk);
        #1;
        checkOutput("bundle", 64'(dutBundle()), 64'(nx));
        last_stall = es;
    endtask

    initial begin
        logic [15:0] base [16];
        logic [15:0] mask [16];
        logic [15:0] cur_i;
        logic        cur_v;
        int stall_high, starts, wb_at, early_cv;

        reset = 1; instr = 0; instr_valid = 0; FlagsReg = 0;
        @(posedge clk);
        #1;

        applyStimulus(16'h0000, 0, 4'h0, 1);
        checkOutput("rstValid", 64'(ctrl_valid), 64'd0);
        checkOutput("rstBrSel", 64'(brSel), 64'd3);

        applyStimulus(16'h1C48, 1, 4'h0, 0);
        checkOutput("addsValid", 64'(ctrl_valid), 64'd1);
        checkOutput("addsRegWrite", 64'(RegWrite), 64'd1);
        checkOutput("addsKeepFlags", 64'(keepFlags), 64'hF);
        checkOutput("addsSelOpB", 64'(selOpB), 64'd1);
        checkOutput("addsALUOp", 64'(ALUOp), 64'd0);
        checkOutput("addsBrSel", 64'(brSel), 64'd3);

        applyStimulus(16'h7600, 1, 4'h0, 0);
        checkOutput("fdivStart", 64'(fpu_start), 64'd1);
        stall_high = 0; starts = 0; wb_at = -1; early_cv = 0;
        for (int k = 1; k <= 9; k++) begin
            applyStimulus(16'h0000, 0, 4'h0, 0);
            stall_high += int'(seen_stall);
            starts += int'(fpu_start);
            if (ctrl_valid && RegWrite && ALUorFPU) wb_at = k;
            if (k <= 7 && ctrl_valid) early_cv++;
        end
        checkOutput("fdivStallCycles", 64'(stall_high), 64'd8);
        checkOutput("fdivExtraStarts", 64'(starts), 64'd0);
        checkOutput("fdivWbCycle", 64'(wb_at), 64'd8);
        checkOutput("fdivEarlyValid", 64'(early_cv), 64'd0);

        applyStimulus(16'h4280, 1, 4'h0, 0);
        applyStimulus(16'hD000, 1, 4'h0, 0);
        checkOutput("hazStall", 64'(seen_stall), 64'd1);
        checkOutput("hazBubble", 64'(ctrl_valid), 64'd0);
        applyStimulus(16'hD000, 1, 4'h4, 0);
        checkOutput("beqValid", 64'(ctrl_valid), 64'd1);
        checkOutput("beqBrSel", 64'(brSel), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(16'h1C48, 1, 4'h4, 0);
            checkOutput("flushWindow", 64'(ctrl_valid), (k == 3) ? 64'd1 : 64'd0);
        end

        applyStimulus(16'h4600, 1, 4'h4, 0);
        applyStimulus(16'hD100, 1, 4'h4, 0);
        checkOutput("bneBrSel", 64'(brSel), 64'd3);
        applyStimulus(16'h1C48, 1, 4'h4, 0);
        checkOutput("bneNoFlush", 64'(ctrl_valid), 64'd1);
        applyStimulus(16'h4600, 1, 4'h0, 0);
        applyStimulus(16'hE000, 1, 4'h0, 0);
        checkOutput("bBrSel", 64'(brSel), 64'd2);
        applyStimulus(16'h1C48, 1, 4'h0, 0);
        checkOutput("bSquash", 64'(ctrl_valid), 64'd0);
        applyStimulus(16'h1C48, 1, 4'h0, 0);
        applyStimulus(16'h4700, 1, 4'h0, 0);
        checkOutput("bxBrEx", 64'(brEx), 64'd1);
        applyStimulus(16'h1C48, 1, 4'h0, 0);
        applyStimulus(16'h1C48, 1, 4'h0, 0);

        applyStimulus(16'h7600, 1, 4'h0, 0);
        for (int k = 1; k <= 4; k++) applyStimulus(16'h0000, 0, 4'h0, 0);
        applyStimulus(16'h0000, 0, 4'h0, 1);
        checkOutput("midRstValid", 64'(ctrl_valid), 64'd0);
        checkOutput("midRstRegWrite", 64'(RegWrite), 64'd0);
        checkOutput("midRstBrSel", 64'(brSel), 64'd3);
        applyStimulus(16'h1C48, 1, 4'h0, 0);
        checkOutput("postRstAccept", 64'(ctrl_valid), 64'd1);
        for (int k = 0; k < 10; k++) applyStimulus(16'h0000, 0, 4'h0, 0);

        base[0]  = 16'h1800; mask[0]  = 16'h07FF;
        base[1]  = 16'hB000; mask[1]  = 16'h00FF;
        base[2]  = 16'h2000; mask[2]  = 16'h0FFF;
        base[3]  = 16'h4600; mask[3]  = 16'h00FF;
        base[4]  = 16'h4280; mask[4]  = 16'h003F;
        base[5]  = 16'h4280; mask[5]  = 16'h003F;
        base[6]  = 16'h4000; mask[6]  = 16'h03FF;
        base[7]  = 16'h6000; mask[7]  = 16'h0FFF;
        base[8]  = 16'hD000; mask[8]  = 16'h0FFF;
        base[9]  = 16'hD000; mask[9]  = 16'h0FFF;
        base[10] = 16'hE000; mask[10] = 16'h07FF;
        base[11] = 16'h4500; mask[11] = 16'h003F;
        base[12] = 16'h4700; mask[12] = 16'h00FF;
        base[13] = 16'h7000; mask[13] = 16'h07FF;
        base[14] = 16'h7800; mask[14] = 16'h003F;
        base[15] = 16'h0000; mask[15] = 16'hFFFF;
        cur_i = 16'h0000; cur_v = 0;
        for (int n = 0; n < 3000; n++) begin
            int idx;
            if (!last_stall) begin
                idx = $urandom_range(0, 15);
                cur_i = base[idx] | (16'($urandom) & mask[idx]);
                cur_v = ($urandom_range(0, 99) < 85);
            end
            applyStimulus(cur_i, cur_v, 4'($urandom), ($urandom_range(0, 199) == 0));
        end

        applyStimulus(16'h0000, 0, 4'h0, 1);
        applyStimulus(16'h4280, 1, 4'h0, 0);
        applyStimulus(16'hD000, 1, 4'h0, 0);
        checkOutput("noBubbleStall", 64'(seen_stall_b), 64'd0);
        checkOutput("noBubbleValid", 64'(ctrl_valid_b), 64'd1);
        checkOutput("noBubbleBranch", 64'(Branch_b), 64'd1);
        checkOutput("noBubbleBrSelNT", 64'(brSel_b), 64'd3);
        applyStimulus(16'h4280, 1, 4'h4, 0);
        applyStimulus(16'hD000, 1, 4'h4, 0);
        checkOutput("noBubbleStall2", 64'(seen_stall_b), 64'd0);
        checkOutput("noBubbleBrSelT", 64'(brSel_b), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
